// File: rtl/osd_dem_uart_arb_pkg.sv
// Shared types and constants for the UART DEM character-stream arbiter.
// Optional build macro: OSD_DEM_UART_ARB_TAG_EN adds the TAG state that
// prefixes every grant with a requester tag character.
package osd_dem_uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1
`ifdef OSD_DEM_UART_ARB_TAG_EN
    ,
    ST_TAG   = 2'd2
`endif
  } arb_state_t;

  localparam logic [7:0] CHAR_NEWLINE = 8'h0A;
  localparam logic [7:0] TAG_BASE     = 8'h80;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/osd_dem_uart_rr_pick.sv
// Combinational rotate-priority picker: first valid index at or after the
// pointer, wrapping around NUM_REQ.
module osd_dem_uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDW-1:0]     i_ptr,
  output logic [IDW-1:0]     o_winner,
  output logic               o_any
);

  // Scan from the farthest offset down so the nearest valid index wins last.
  always_comb begin
    int idx;
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    idx      = 0;
    o_winner = '0;
    o_any    = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(i_ptr) + i) % NUM_REQ;
      if (i_valid[idx]) begin
        o_winner = IDW'(idx);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/osd_dem_uart_arb.sv
// Round-robin arbiter sharing the UART DEM character stream between NUM_REQ
// producers. A grant is held until newline, MAX_BURST chars or IDLE_TIMEOUT
// idle cycles. Output is a one-entry register honouring out_ready and stall.
// Optional build macro: OSD_DEM_UART_ARB_TAG_EN (emit 8'h80|grant_id per grant).
module osd_dem_uart_arb
  import osd_dem_uart_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int MAX_BURST    = 64,
  parameter  int IDLE_TIMEOUT = 16,
  localparam int IDW          = id_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*NUM_REQ-1:0] req_char,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           out_char,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 stall,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
);

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST);
  localparam logic [7:0] IDLE_LAST  = 8'(IDLE_TIMEOUT);

  arb_state_t     r_state;
  arb_state_t     w_state_nxt;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_grant;
  logic [IDW-1:0] w_winner;
  logic           w_any;
  logic [7:0]     r_burst_cnt;
  logic [7:0]     r_idle_cnt;
  logic [7:0]     r_out_char;
  logic           r_out_valid;
  logic [7:0]     w_gchar;
  logic           w_gvalid;
  logic           w_slot_free;
  logic           w_pick;
  logic           w_xfer;
  logic           w_idle_tick;
  logic           w_release;
  logic           w_load_tag;

  osd_dem_uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .i_valid  (req_valid),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // Select the granted requester's char and valid lane.
  always_comb begin
    w_gchar  = '0;
    w_gvalid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == r_grant) begin
        w_gchar  = req_char[8*i +: 8];
        w_gvalid = req_valid[i];
      end
    end
  end

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_pick      = (r_state == ST_IDLE) && w_any;
  assign w_xfer      = (r_state == ST_GRANT) && w_gvalid && !stall && w_slot_free;
  assign w_idle_tick = (r_state == ST_GRANT) && !w_gvalid && !stall;
  // Newline on the last burst char is one release, not two.
  assign w_release   = (w_xfer && ((w_gchar == CHAR_NEWLINE) || (r_burst_cnt + 8'd1 == BURST_LAST)))
                    || (w_idle_tick && (r_idle_cnt + 8'd1 == IDLE_LAST));
`ifdef OSD_DEM_UART_ARB_TAG_EN
  assign w_load_tag  = (r_state == ST_TAG) && !stall && w_slot_free;
`else
  assign w_load_tag  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: reset is asynchronous, so outputs clear the moment rst rises, not at the next edge.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
`ifdef OSD_DEM_UART_ARB_TAG_EN
      ST_IDLE:  if (w_any)      w_state_nxt = ST_TAG;
      ST_TAG:   if (w_load_tag) w_state_nxt = ST_GRANT;
`else
      ST_IDLE:  if (w_any)      w_state_nxt = ST_GRANT;
`endif
      ST_GRANT: if (w_release)  w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  // Ready goes only to the granted requester, and only when the output slot frees.
  always_comb begin
    req_ready = '0;
    if (r_state == ST_GRANT) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (IDW'(i) == r_grant) req_ready[i] = !stall && w_slot_free;
      end
    end
  end

  // Arbitration pointer, grant id and per-grant burst/idle counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_grant     <= '0;
      r_burst_cnt <= '0;
      r_idle_cnt  <= '0;
    end else if (w_pick) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_grant     <= w_winner;
      r_ptr       <= (w_winner == IDW'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
      r_burst_cnt <= '0;
      r_idle_cnt  <= '0;
    end else if (w_xfer) begin
      r_burst_cnt <= r_burst_cnt + 8'd1;
      r_idle_cnt  <= '0;
    end else if (w_idle_tick) begin
      r_idle_cnt  <= r_idle_cnt + 8'd1;
    end
  end

  // One-entry output register; a pending char survives release and stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_char  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_out_char  <= w_gchar;
      r_out_valid <= 1'b1;
    end else if (w_load_tag) begin
      r_out_char  <= TAG_BASE | 8'(r_grant);
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_char  = r_out_char;
  assign out_valid = r_out_valid;
  assign grant_id  = r_grant;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_osd_dem_uart_arb.sv
// Directed bench for osd_dem_uart_arb (NUM_REQ=4, MAX_BURST=64, IDLE_TIMEOUT=16).
// Inputs are driven on the falling edge; outputs are sampled 1 ns later.
module tb_osd_dem_uart_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] req_char = '0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [7:0]  out_char;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  osd_dem_uart_arb #(
    .NUM_REQ      (4),
    .MAX_BURST    (64),
    .IDLE_TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_char  (req_char),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .out_char  (out_char),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .stall     (stall),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    logic [7:0] c0;
    logic [7:0] c2;
    logic [3:0] rdy;
    logic       ov;
    logic [7:0] oc;
    logic       bsy;
    logic [1:0] gid;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] char_of(input int n);
    return 8'h41 + 8'(n % 26);
  endfunction

  task automatic check_reset(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 0);
    check({tag, " out_char"},  32'(out_char),  0);
    check({tag, " req_ready"}, 32'(req_ready), 0);
    check({tag, " grant_id"},  32'(grant_id),  0);
    check({tag, " busy"},      32'(busy),      0);
  endtask

  // Counts granted-but-idle cycles until busy falls; bounded.
  task automatic count_idle(input int want, input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      req_valid[0] = 1'b0;
      #1;
      if (!busy) done = 1'b1;
      else       n++;
    end
    check({name, " released"}, 32'(done), 1);
    check({name, " idle cycles"}, 32'(n), 32'(want));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

`ifdef OSD_DEM_UART_ARB_TAG_EN
    begin : tag_test
      logic [7:0] seen [$];
      bit dropped;
      dropped = 1'b0;
      req_valid = 4'b0100;
      req_char[23:16] = 8'h78;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        #1;
        if (out_valid) seen.push_back(out_char);
        if (req_ready[2] && req_valid[2]) dropped = 1'b1;
        else if (dropped) req_valid = 4'b0000;
      end
      check("tag stream len", 32'(seen.size()), 2);
      if (seen.size() >= 2) begin
        check("tag char", 32'(seen[0]), 32'h82);
        check("tag data", 32'(seen[1]), 32'h78);
      end
    end
`else
    // Test 1: two requesters each send "ab\n"; lines must not interleave.
    tbl[0] = '{4'b0101, 8'h61, 8'h61, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[1] = '{4'b0101, 8'h61, 8'h61, 4'b0001, 1'b0, 8'h00, 1'b1, 2'd0};
    tbl[2] = '{4'b0101, 8'h62, 8'h61, 4'b0001, 1'b1, 8'h61, 1'b1, 2'd0};
    tbl[3] = '{4'b0101, 8'h0A, 8'h61, 4'b0001, 1'b1, 8'h62, 1'b1, 2'd0};
    tbl[4] = '{4'b0100, 8'h00, 8'h61, 4'b0000, 1'b1, 8'h0A, 1'b0, 2'd0};
    tbl[5] = '{4'b0100, 8'h00, 8'h61, 4'b0100, 1'b0, 8'h00, 1'b1, 2'd2};
    tbl[6] = '{4'b0100, 8'h00, 8'h62, 4'b0100, 1'b1, 8'h61, 1'b1, 2'd2};
    tbl[7] = '{4'b0100, 8'h00, 8'h0A, 4'b0100, 1'b1, 8'h62, 1'b1, 2'd2};
    tbl[8] = '{4'b0000, 8'h00, 8'h00, 4'b0000, 1'b1, 8'h0A, 1'b0, 2'd2};
    tbl[9] = '{4'b0000, 8'h00, 8'h00, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd2};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid       = tbl[i].v;
      req_char[7:0]   = tbl[i].c0;
      req_char[23:16] = tbl[i].c2;
      #1;
      check($sformatf("t1[%0d] req_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      check($sformatf("t1[%0d] out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      check($sformatf("t1[%0d] busy", i),      32'(busy),      32'(tbl[i].bsy));
      check($sformatf("t1[%0d] grant_id", i),  32'(grant_id),  32'(tbl[i].gid));
      if (tbl[i].ov) check($sformatf("t1[%0d] out_char", i), 32'(out_char), 32'(tbl[i].oc));
    end

    // Test 2: req1 streams without newline; forced release after 64 chars, waiting req3 next.
    begin : burst_test
      int  sent;
      bit  released;
      sent = 0;
      released = 1'b0;
      @(negedge clk);
      req_valid = 4'b0010;
      req_char[15:8] = char_of(0);
      for (int k = 0; k < 200 && !released; k++) begin
        @(negedge clk);
        req_valid = 4'b1010;
        req_char[15:8]  = char_of(sent);
        req_char[31:24] = 8'h0A;
        #1;
        if (!busy) released = 1'b1;
        else if (req_ready[1]) sent++;
      end
      check("burst released", 32'(released), 1);
      check("burst length", 32'(sent), 64);
      check("burst last char", 32'(out_char), 32'(char_of(63)));
      check("burst ready after release", 32'(req_ready), 0);
      @(negedge clk);
      #1;
      check("burst next grant", 32'(grant_id), 3);
      check("burst next busy", 32'(busy), 1);
      check("burst next ready", 32'(req_ready), 32'b1000);
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      check("req3 newline release", 32'(busy), 0);
      check("req3 newline out", 32'(out_char), 32'h0A);
    end

    // Test 3: req0 sends 3 chars then goes quiet; release after exactly 16 idle cycles.
    @(negedge clk);
    req_valid = 4'b0011;
    req_char[7:0] = 8'h78;
    req_char[15:8] = 8'h51;
    #1;
    check("timeout idle before pick", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_char[7:0] = 8'h78 + 8'(i);
      #1;
      check($sformatf("timeout xfer%0d ready", i), 32'(req_ready), 32'b0001);
    end
    count_idle(16, "timeout");
    check("timeout grant held", 32'(grant_id), 0);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("timeout next grant", 32'(grant_id), 1);
    check("timeout next busy", 32'(busy), 1);

    // Test 4: req1 char 'Q' pending, 5 idle cycles, then 10 stalled cycles.
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    check("stall pending valid", 32'(out_valid), 1);
    check("stall pending char", 32'(out_char), 32'h51);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      stall = 1'b1;
      #1;
      check($sformatf("stall[%0d] out_char", k),  32'(out_char),  32'h51);
      check($sformatf("stall[%0d] out_valid", k), 32'(out_valid), 1);
      check($sformatf("stall[%0d] req_ready", k), 32'(req_ready), 0);
      check($sformatf("stall[%0d] busy", k),      32'(busy),      1);
    end
    @(negedge clk);
    stall = 1'b0;
    out_ready = 1'b1;
    #1;
    check("stall unstall ready", 32'(req_ready), 32'b0010);
    count_idle(10, "stall frozen idle");

    // Test 5: reset while req2 holds a pending char.
    @(negedge clk);
    req_valid = 4'b0100;
    req_char[23:16] = 8'h6D;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    check("rst pre grant", 32'(grant_id), 2);
    @(negedge clk);
    #1;
    check("rst pre out_valid", 32'(out_valid), 1);
    check("rst pre out_char", 32'(out_char), 32'h6D);
    #2;
    rst = 1'b1;
    #1;
    check_reset("midreset");
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("post reset grant", 32'(grant_id), 0);
    check("post reset busy", 32'(busy), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
